// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the pipeline and a simple
// request/acknowledge memory port.
//
// Ports:
//   i_clk, i_reset     clock, asynchronous active-low reset
//   i_req              pipeline access request (sampled only when idle)
//   i_wren             1 = store, 0 = load
//   i_load_type        000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   i_st_type          00 SB, 01 SH, 10 SW
//   i_addr, i_st_data  byte address and store data
//   o_busy             access in progress (pipeline stall)
//   o_done, o_err      one-cycle completion pulse, abort flag valid with it
//   o_ld_data          extended load result, valid with o_done
//   o_mem_*            memory request, write enable, word address,
//                      byte-lane mask and lane-replicated write data
//   i_mem_ack          memory accepted request; i_mem_rdata valid with it
//   i_mem_rdata        memory read word
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_wren,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_st_type,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          r_wren;
  logic          r_unsigned;
  logic [1:0]    r_size;
  logic [1:0]    r_lane;

  // Request decode: size code 00 byte, 01 half, 10 word
  logic [1:0]  acc_size;
  logic        legal_type;
  logic        aligned;
  logic [3:0]  bmask_in;
  logic [31:0] wdata_in;

  always_comb begin
    acc_size   = i_wren ? i_st_type : i_load_type[1:0];
    legal_type = i_wren ? (i_st_type != 2'b11)
                        : ((i_load_type[1:0] != 2'b11) &&
                           !(i_load_type[2] && i_load_type[1]));
    aligned    = 1'b0;
    bmask_in   = 4'b1111;
    wdata_in   = i_st_data;
    case (acc_size)
      2'b00: begin
        aligned  = 1'b1;
        bmask_in = 4'b0001 << i_addr[1:0];
        wdata_in = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        aligned  = !i_addr[0];
        bmask_in = 4'b0011 << i_addr[1:0];
        wdata_in = {2{i_st_data[15:0]}};
      end
      2'b10: begin
        aligned  = (i_addr[1:0] == 2'b00);
      end
      default: aligned = 1'b0;
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend
  logic [31:0] lane_data;
  logic [31:0] ld_ext;

  always_comb begin
    lane_data = i_mem_rdata >> {r_lane, 3'b000};
    case (r_size)
      2'b00:   ld_ext = r_unsigned ? {24'b0, lane_data[7:0]}
                                   : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   ld_ext = r_unsigned ? {16'b0, lane_data[15:0]}
                                   : {{16{lane_data[15]}}, lane_data[15:0]};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      r_wren      <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= '0;
      r_lane      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_ld_data   <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_bmask <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            r_wren     <= i_wren;
            r_unsigned <= i_load_type[2];
            r_size     <= acc_size;
            r_lane     <= i_addr[1:0];
            o_busy     <= 1'b1;
            if (legal_type && aligned) begin
              state       <= REQ;
              wait_cnt    <= '0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_wren;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_bmask <= bmask_in;
              o_mem_wdata <= wdata_in;
            end else begin
              // Rejected access skips memory and reports straight away
              state     <= RESP;
              o_done    <= 1'b1;
              o_err     <= 1'b1;
              o_ld_data <= '0;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            state     <= RESP;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= 1'b0;
            o_ld_data <= r_wren ? '0 : ld_ext;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            o_ld_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          o_err  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          o_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized scoreboard bench for lsu_ctrl. The driver pushes
// expected completions and expected memory transactions into queues; a
// memory responder and a completion monitor pop and compare independently.
module tb_lsu_ctrl;
  localparam int unsigned TO = 16;

  logic        i_clk;
  logic        i_reset;
  logic        i_req;
  logic        i_wren;
  logic [2:0]  i_load_type;
  logic [1:0]  i_st_type;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_ld_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_bmask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_wren      (i_wren),
    .i_load_type (i_load_type),
    .i_st_type   (i_st_type),
    .i_addr      (i_addr),
    .i_st_data   (i_st_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_ld_data   (o_ld_data),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_bmask (o_mem_bmask),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  typedef struct {
    logic        wren;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int unsigned delay;   // ack in this REQ cycle (0-based); >= TO means never
  } txn_t;

  typedef struct {
    logic        err;
    logic [31:0] ld;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bmask;
    logic [31:0] wdata;
    int unsigned delay;
    logic [31:0] rdata;
  } mem_t;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  bit          in_reset = 1'b1;
  done_t       done_q[$];
  mem_t        mem_q[$];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Access size in bytes, 0 for an illegal encoding.
  function automatic int unsigned acc_bytes(input txn_t t);
    if (t.wren) begin
      case (t.st)
        2'd0: return 1;
        2'd1: return 2;
        2'd2: return 4;
        default: return 0;
      endcase
    end
    case (t.lt)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input txn_t t, input int unsigned nb);
    int unsigned off = t.addr % 4;
    logic [31:0] v = t.rdata >> (8 * off);
    logic [31:0] keep;
    if (nb == 4) return t.rdata;
    keep = (32'h1 << (8 * nb)) - 32'h1;
    v = v & keep;
    if (t.lt <= 3'd1 && v[8*nb-1]) v = v | ~keep;
    return v;
  endfunction

  function automatic txn_t mk(input logic wren, input logic [2:0] lt, input logic [1:0] st,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rdata, input int unsigned delay);
    txn_t t;
    t.wren = wren; t.lt = lt; t.st = st; t.addr = addr;
    t.sd = sd; t.rdata = rdata; t.delay = delay;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input txn_t t, input bit hold);
    int unsigned nb;
    int unsigned n;
    bit          legal;
    done_t       d;
    mem_t        m;
    i_req = 1'b1;
    i_wren = t.wren; i_load_type = t.lt; i_st_type = t.st;
    i_addr = t.addr; i_st_data = t.sd;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL accept_timeout: o_busy=%b expected 0 within 100 cycles", o_busy);
    end
    nb    = acc_bytes(t);
    legal = (nb != 0) && ((t.addr % nb) == 0);
    d.err = !legal || (t.delay >= TO);
    d.ld  = (d.err || t.wren) ? 32'h0 : load_value(t, nb);
    done_q.push_back(d);
    if (legal) begin
      m.we    = t.wren;
      m.addr  = t.addr & ~32'h3;
      m.bmask = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << (t.addr % 4));
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = t.sd[8*(i % nb) +: 8];
      m.delay = t.delay;
      m.rdata = t.rdata;
      mem_q.push_back(m);
    end
    @(posedge i_clk);
    #1;
    // inputs after the accept edge must not disturb the access
    i_req = hold;
    i_wren = 1'($urandom()); i_load_type = 3'($urandom()); i_st_type = 2'($urandom());
    i_addr = $urandom(); i_st_data = $urandom();
    @(negedge i_clk);
  endtask

  // ---------------- memory responder + request checker ----------------
  initial begin
    int unsigned req_cycles = 0;
    bit          cur_valid = 1'b0;
    mem_t        cur;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (in_reset) begin
        req_cycles = 0;
        cur_valid  = 1'b0;
        i_mem_ack  = 1'b0;
      end else if (o_mem_req) begin
        if (req_cycles == 0) begin
          checks++;
          if (mem_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_mem_req: o_mem_req=1 expected 0");
            cur_valid = 1'b0;
          end else begin
            cur = mem_q[0];
            cur_valid = 1'b1;
          end
        end
        if (cur_valid) begin
          check("mem_addr", o_mem_addr, cur.addr);
          check("mem_bmask", {28'b0, o_mem_bmask}, {28'b0, cur.bmask});
          check("mem_wdata", o_mem_wdata, cur.wdata);
          check("mem_we", {31'b0, o_mem_we}, {31'b0, cur.we});
          i_mem_ack   = (req_cycles == cur.delay);
          i_mem_rdata = i_mem_ack ? cur.rdata : $urandom();
        end else begin
          i_mem_ack = 1'b0;
        end
        req_cycles++;
      end else begin
        if (req_cycles > 0 && cur_valid) begin
          check("req_cycles", req_cycles, (cur.delay < TO) ? cur.delay + 1 : TO);
          void'(mem_q.pop_front());
        end
        req_cycles = 0;
        cur_valid  = 1'b0;
        check("mem_we_idle", {31'b0, o_mem_we}, 32'h0);
        // stray acks while no request is outstanding
        i_mem_ack   = ($urandom_range(3) == 0);
        i_mem_rdata = $urandom();
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    bit    prev_done = 1'b0;
    done_t e;
    forever begin
      @(negedge i_clk);
      if (o_done) begin
        checks++;
        if (prev_done) begin
          fails++;
          $display("FAIL done_merge: o_done high 2 cycles, expected single pulse");
        end
        check("done_busy", {31'b0, o_busy}, 32'h1);
        checks++;
        if (done_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: o_done=1 expected 0");
        end else begin
          e = done_q.pop_front();
          check("err", {31'b0, o_err}, {31'b0, e.err});
          check("ld_data", o_ld_data, e.ld);
        end
      end
      prev_done = o_done;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {27'b0, o_busy, o_done, o_err, o_mem_req, o_mem_we}, 32'h0);
    check({tag, "_ld"}, o_ld_data, 32'h0);
    check({tag, "_maddr"}, o_mem_addr, 32'h0);
    check({tag, "_mbmask"}, {28'b0, o_mem_bmask}, 32'h0);
    check({tag, "_mwdata"}, o_mem_wdata, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    txn_t        t;
    bit          hold;
    int unsigned nb;
    int unsigned r;
    int unsigned n;
    logic [2:0]  legal_lt [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    i_reset = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_load_type = '0;
    i_st_type = '0; i_addr = '0; i_st_data = '0;
    #3 i_reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge i_clk);
    i_reset  = 1'b1;
    in_reset = 1'b0;

    // directed cases
    issue(mk(1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FF_0000, 1), 1'b0);  // LB
    issue(mk(1'b1, 3'b000, 2'b01, 32'h22, 32'h1234_ABCD, 32'h0, 0), 1'b0);   // SH
    issue(mk(1'b0, 3'b010, 2'b00, 32'h41, 32'h0, 32'h0, 0), 1'b0);           // LW misaligned
    issue(mk(1'b0, 3'b101, 2'b00, 32'h10, 32'h0, 32'h0, TO), 1'b0);          // LHU timeout
    issue(mk(1'b0, 3'b101, 2'b00, 32'h12, 32'h0, 32'hBEEF_0000, TO - 1), 1'b0); // ack in last cycle
    issue(mk(1'b0, 3'b011, 2'b00, 32'h40, 32'h0, 32'h0, 0), 1'b0);           // illegal load types
    issue(mk(1'b0, 3'b110, 2'b00, 32'h40, 32'h0, 32'h0, 0), 1'b0);
    issue(mk(1'b0, 3'b111, 2'b00, 32'h40, 32'h0, 32'h0, 0), 1'b0);
    issue(mk(1'b1, 3'b000, 2'b11, 32'h40, 32'h0, 32'h0, 0), 1'b0);           // illegal store
    issue(mk(1'b1, 3'b000, 2'b01, 32'h43, 32'h5555, 32'h0, 0), 1'b1);        // SH misaligned, held req
    issue(mk(1'b1, 3'b000, 2'b10, 32'h42, 32'h5555, 32'h0, 0), 1'b1);        // SW misaligned
    issue(mk(1'b1, 3'b000, 2'b00, 32'h7, 32'h0000_00A5, 32'h0, 2), 1'b1);     // SB lane 3
    issue(mk(1'b0, 3'b001, 2'b00, 32'h2, 32'h0, 32'h8001_7FFF, 0), 1'b1);     // LH upper half
    issue(mk(1'b0, 3'b010, 2'b00, 32'h80, 32'h0, 32'hCAFE_F00D, 3), 1'b0);   // LW

    // randomized traffic
    for (int k = 0; k < 200; k++) begin
      t.wren = 1'($urandom_range(1));
      t.lt   = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : legal_lt[$urandom_range(4)];
      t.st   = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      t.addr = $urandom();
      nb = acc_bytes(t);
      if ($urandom_range(2) != 0) begin
        if (nb == 2) t.addr[0] = 1'b0;
        if (nb == 4) t.addr[1:0] = 2'b00;
      end
      t.sd    = $urandom();
      t.rdata = $urandom();
      r = $urandom_range(9);
      t.delay = (r == 9) ? TO : (r == 8) ? TO - 1 : $urandom_range(3);
      hold = ($urandom_range(3) == 0);
      issue(t, hold);
      if (!hold) repeat ($urandom_range(2)) @(negedge i_clk);
    end
    i_req = 1'b0;

    // reset in the middle of a REQ phase
    issue(mk(1'b0, 3'b101, 2'b00, 32'h10, 32'h0, 32'h0, TO), 1'b0);
    repeat (3) @(negedge i_clk);
    #2;
    in_reset = 1'b1;
    i_reset  = 1'b0;
    #1 check_all_zero("midreset");
    done_q.delete();
    mem_q.delete();
    repeat (3) @(negedge i_clk);
    i_reset  = 1'b1;
    in_reset = 1'b0;
    issue(mk(1'b0, 3'b100, 2'b00, 32'h1, 32'h0, 32'h0000_9A00, 1), 1'b0);    // LBU after reset

    n = 0;
    while ((done_q.size() != 0 || mem_q.size() != 0) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (done_q.size() != 0 || mem_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d completions and %0d requests outstanding, expected 0",
               done_q.size(), mem_q.size());
    end
    repeat (3) @(negedge i_clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
